// File: rtl/gcd_operand_sequencer_if.sv
// gcd_operand_sequencer_if: groups the signals around the operand sequencer.
// These are the operand-pair input port, the GCD core bus, the result output
// port and the status outputs.
// The master side is the sequencer itself; the slave side is its environment
// (producer, GCD core and consumer).
interface gcd_operand_sequencer_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          gcd_start;
    logic [W-1:0]  gcd_data;
    logic [W-1:0]  gcd_result;
    logic          gcd_done;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_err;
    logic          busy;
    logic [CW-1:0] fifo_count;

    modport master (
        input  in_valid, in_a, in_b, gcd_result, gcd_done, out_ready,
        output in_ready, gcd_start, gcd_data, out_valid, out_result, out_err,
               busy, fifo_count
    );

    modport slave (
        output in_valid, in_a, in_b, gcd_result, gcd_done, out_ready,
        input  in_ready, gcd_start, gcd_data, out_valid, out_result, out_err,
               busy, fifo_count
    );
endinterface

// File: rtl/gcd_operand_sequencer.sv
// gcd_operand_sequencer: buffers operand pairs in a small FIFO.
// Each pair is serialised onto the GCD core bus (A then B under start), and the
// sequencer then waits for done under a timeout.
// The result, or an error on timeout, is held on a valid/ready output.
// Pairs with a zero operand bypass the core entirely.
module gcd_operand_sequencer #(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gcd_operand_sequencer_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD_A = 2'd1;
    localparam logic [1:0] S_LOAD_B = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [1:0]    r_state;
    logic [W-1:0]  r_mem_a [DEPTH];
    logic [W-1:0]  r_mem_b [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_op_a;
    logic [W-1:0]  r_op_b;
    logic [TW-1:0] r_timer;
    logic          r_out_valid;
    logic          r_out_err;
    logic [W-1:0]  r_out_result;

    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic [W-1:0]  w_head_a;
    logic [W-1:0]  w_head_b;
    logic          w_head_bypass;

    // in_ready depends only on the registered count, so there is no path from in_valid.
    assign w_in_ready    = (r_count < FULL_COUNT);
    assign w_push        = bus.in_valid && w_in_ready;
    // A new job is only taken once the previous result has been handed off.
    assign w_pop         = (r_state == S_IDLE) && (r_count != '0) && !r_out_valid;
    assign w_head_a      = r_mem_a[r_rd_ptr];
    assign w_head_b      = r_mem_b[r_rd_ptr];
    assign w_head_bypass = (w_head_a == '0) || (w_head_b == '0);

    assign bus.in_ready   = w_in_ready;
    assign bus.gcd_start  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign bus.gcd_data   = (r_state == S_LOAD_A) ? r_op_a : r_op_b;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_err    = r_out_err;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.fifo_count = r_count;

    // Pair storage; the pointers and count alone define which entries are live, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= bus.in_a;
            r_mem_b[r_wr_ptr] <= bus.in_b;
        end
    end

    // FIFO pointers wrap naturally at DEPTH; a simultaneous push and pop leaves the count as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= PW'(r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= PW'(r_rd_ptr + 1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= CW'(r_count + 1'b1);
                2'b01:   r_count <= CW'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Job sequencing and result register: pop, bypass or load A/B, then wait for done or time out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_timer      <= '0;
            r_out_valid  <= 1'b0;
            r_out_err    <= 1'b0;
            r_out_result <= '0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_op_a <= w_head_a;
                        r_op_b <= w_head_b;
                        if (w_head_bypass) begin
                            r_out_valid  <= 1'b1;
                            r_out_err    <= 1'b0;
                            r_out_result <= (w_head_a != '0) ? w_head_a : w_head_b;
                        end else begin
                            r_state <= S_LOAD_A;
                        end
                    end
                end
                S_LOAD_A: begin
                    r_state <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    r_state <= S_WAIT;
                    r_timer <= '0;
                end
                S_WAIT: begin
                    if (bus.gcd_done) begin
                        r_out_valid  <= 1'b1;
                        r_out_err    <= 1'b0;
                        r_out_result <= bus.gcd_result;
                        r_state      <= S_IDLE;
                    end else if (r_timer == TIMER_LAST) begin
                        r_out_valid  <= 1'b1;
                        r_out_err    <= 1'b1;
                        r_out_result <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_timer <= TW'(r_timer + 1'b1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// tb_gcd_operand_sequencer: drives operand pairs into the sequencer.
// A behavioural GCD core answers each job after a chosen delay.
// Every handed-off result is compared against an Euclid-based reference scoreboard.
module tb_gcd_operand_sequencer;
    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gcd_operand_sequencer_if #(.W(W), .DEPTH(DEPTH)) bus ();

    gcd_operand_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared = 0;
    int mismatched = 0;

    logic [W-1:0] expRes[$];
    logic         expErr[$];
    int           coreDelayQ[$];
    logic [W-1:0] coreAQ[$];
    logic [W-1:0] coreBQ[$];

    bit           randReady = 1'b0;
    bit           readyForce = 1'b1;
    bit           manualDone = 1'b0;
    logic [W-1:0] manualRes = '0;
    int           startCount = 0;

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference GCD by Euclid's remainder method.
    function automatic logic [W-1:0] refGcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    // Consumer ready: either random per cycle or a fixed level chosen by the main sequence.
    always @(posedge clk) begin
        #1;
        if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
        else           bus.out_ready = readyForce;
    end

    // Behavioural GCD core: takes A then B under start, answers after the job's delay (negative = never).
    bit           gotA = 1'b0;
    int           startRun = 0;
    bit           coreWaiting = 1'b0;
    int           coreLeft = 0;
    logic [W-1:0] coreRes = '0;
    always @(negedge clk) begin
        int d;
        logic [W-1:0] a;
        logic [W-1:0] b;
        if (!rst_n) begin
            gotA = 1'b0;
            startRun = 0;
            coreWaiting = 1'b0;
            bus.gcd_done = 1'b0;
            bus.gcd_result = '0;
        end else begin
            bus.gcd_done = 1'b0;
            if (manualDone) begin
                bus.gcd_done = 1'b1;
                bus.gcd_result = manualRes;
            end
            if (coreWaiting) begin
                if (coreLeft == 0) begin
                    bus.gcd_done = 1'b1;
                    bus.gcd_result = coreRes;
                    coreWaiting = 1'b0;
                end else begin
                    coreLeft--;
                end
            end
            if (bus.gcd_start) begin
                startCount++;
                startRun++;
                if (coreAQ.size() == 0) begin
                    checkOutput("core_unexpected_start", 1, 0);
                end else if (!gotA) begin
                    gotA = 1'b1;
                    checkOutput("core_data_a", bus.gcd_data, coreAQ[0]);
                end else begin
                    gotA = 1'b0;
                    checkOutput("core_data_b", bus.gcd_data, coreBQ[0]);
                    d = coreDelayQ.pop_front();
                    a = coreAQ.pop_front();
                    b = coreBQ.pop_front();
                    if (d >= 0) begin
                        coreWaiting = 1'b1;
                        coreLeft = d;
                        coreRes = refGcd(a, b);
                    end
                end
            end else if (startRun != 0) begin
                checkOutput("start_len", startRun, 2);
                startRun = 0;
            end
        end
    end

    // Result monitor: scoreboard compare on each handshake, and stability while stalled.
    bit           prevHold = 1'b0;
    logic [W-1:0] prevRes = '0;
    logic         prevErr = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prevHold = 1'b0;
        end else begin
            if (prevHold) begin
                checkOutput("hold_valid", bus.out_valid, 1);
                checkOutput("hold_result", bus.out_result, prevRes);
                checkOutput("hold_err", bus.out_err, prevErr);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expRes.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    checkOutput("out_result", bus.out_result, expRes.pop_front());
                    checkOutput("out_err", bus.out_err, expErr.pop_front());
                end
            end
            prevHold = bus.out_valid && !bus.out_ready;
            prevRes = bus.out_result;
            prevErr = bus.out_err;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Offer one pair and hold it until taken; expectations come from the pair and the core's delay.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int delay);
        int guard = 0;
        if (a == '0 || b == '0) begin
            expRes.push_back((a != '0) ? a : b);
            expErr.push_back(1'b0);
        end else begin
            coreAQ.push_back(a);
            coreBQ.push_back(b);
            coreDelayQ.push_back(delay);
            if (delay < 0 || delay > TIMEOUT - 1) begin
                expRes.push_back('0);
                expErr.push_back(1'b1);
            end else begin
                expRes.push_back(refGcd(a, b));
                expErr.push_back(1'b0);
            end
        end
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) checkOutput("push_timeout", 0, 1);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
    endtask

    // Count negedges until out_valid is seen.
    task automatic waitOutValid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 300);
        if (!bus.out_valid) checkOutput("out_valid_timeout", 0, 1);
        @(posedge clk);
        #2;
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (expRes.size() != 0 && guard < 3000) begin
            waitCycles(1);
            guard++;
        end
        checkOutput("drain_left", expRes.size(), 0);
    endtask

    task automatic checkResetState(input string tag);
        @(negedge clk);
        checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
        checkOutput({tag, "_out_valid"}, bus.out_valid, 0);
        checkOutput({tag, "_out_result"}, bus.out_result, 0);
        checkOutput({tag, "_out_err"}, bus.out_err, 0);
        checkOutput({tag, "_gcd_start"}, bus.gcd_start, 0);
        checkOutput({tag, "_gcd_data"}, bus.gcd_data, 0);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_fifo_count"}, bus.fifo_count, 0);
    endtask

    initial begin
        int n;
        int s0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int rd;

        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        rst_n = 1'b0;
        checkResetState("reset");
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(2);

        // Core job: start for exactly two cycles, done after 10 WAIT cycles.
        s0 = startCount;
        applyStimulus(8'd143, 8'd78, 10);
        waitOutValid(n);
        checkOutput("latency_core", n, 5 + 10);
        waitDrain();
        checkOutput("core_start_cycles", startCount - s0, 2);

        // Zero-operand bypass: result one cycle after the pop, core untouched.
        s0 = startCount;
        applyStimulus(8'd0, 8'd35, 0);
        waitOutValid(n);
        checkOutput("latency_bypass_b", n, 2);
        applyStimulus(8'd42, 8'd0, 0);
        waitOutValid(n);
        checkOutput("latency_bypass_a", n, 2);
        applyStimulus(8'd0, 8'd0, 0);
        waitOutValid(n);
        checkOutput("latency_bypass_zero", n, 2);
        waitDrain();
        checkOutput("bypass_start_cycles", startCount - s0, 0);

        // Result held with out_ready low while the FIFO fills to DEPTH.
        readyForce = 1'b0;
        waitCycles(2);
        applyStimulus(8'd0, 8'd9, 0);
        waitCycles(2);
        s0 = startCount;
        applyStimulus(8'd12, 8'd18, 3);
        applyStimulus(8'd35, 8'd14, 7);
        applyStimulus(8'd9, 8'd6, 0);
        applyStimulus(8'd17, 8'd5, 15);
        @(negedge clk);
        checkOutput("full_in_ready", bus.in_ready, 0);
        checkOutput("full_count", bus.fifo_count, DEPTH);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", bus.out_valid, 1);
            checkOutput("stall_result", bus.out_result, 9);
            checkOutput("stall_count", bus.fifo_count, DEPTH);
        end
        checkOutput("stall_start_cycles", startCount - s0, 0);
        waitCycles(1);
        readyForce = 1'b1;
        applyStimulus(8'd100, 8'd75, 5);
        waitDrain();
        checkOutput("after_full_count", bus.fifo_count, 0);

        // Core never answers: error result after TIMEOUT WAIT cycles, next pair runs normally.
        applyStimulus(8'd91, 8'd35, -1);
        applyStimulus(8'd48, 8'd36, 4);
        waitOutValid(n);
        // One cycle of the nominal 4+TIMEOUT was spent pushing the second pair.
        checkOutput("latency_timeout", n, 4 + TIMEOUT - 1);
        waitDrain();

        // Reset in the middle of a job with two pairs queued; a late done must be ignored.
        applyStimulus(8'd77, 8'd21, -1);
        applyStimulus(8'd30, 8'd12, 2);
        applyStimulus(8'd8, 8'd4, 2);
        waitCycles(6);
        @(negedge clk);
        checkOutput("pre_reset_busy", bus.busy, 1);
        checkOutput("pre_reset_count", bus.fifo_count, 2);
        waitCycles(1);
        rst_n = 1'b0;
        expRes.delete();
        expErr.delete();
        coreAQ.delete();
        coreBQ.delete();
        coreDelayQ.delete();
        checkResetState("midjob_reset");
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(2);
        manualRes = 8'd77;
        manualDone = 1'b1;
        waitCycles(1);
        manualDone = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("post_reset_valid", bus.out_valid, 0);
            checkOutput("post_reset_busy", bus.busy, 0);
            checkOutput("post_reset_count", bus.fifo_count, 0);
        end
        waitCycles(1);

        // Randomised traffic with random consumer backpressure, including done/timeout coincidence.
        randReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 255));
            rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 255));
            rd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
            applyStimulus(ra, rb, rd);
            waitCycles(int'($urandom_range(0, 3)));
        end
        waitDrain();
        randReady = 1'b0;
        waitCycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gcd_operand_sequencer.md
Name: gcd_operand_sequencer

Overview:
Front-end stage that feeds the GCD core and collects its answer. It accepts operand pairs (A, B) on a valid/ready port and buffers them in a small FIFO. Each pair is serialised onto the core's start/data_in bus as A then B on consecutive cycles. The sequencer waits for done, then presents the result on a valid/ready output. It also short-circuits zero operands and enforces a done timeout.

Parameters:
W, 8, operand/result width in bits
DEPTH, 4, operand-pair FIFO depth (power of 2, >=2)
TIMEOUT, 256, max cycles in WAIT before the job is aborted

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair offered
in_ready  out  1  FIFO can accept a pair
in_a  in  W  operand A
in_b  in  W  operand B
gcd_start  out  1  to core start
gcd_data  out  W  to core data_in
gcd_result  in  W  from core result
gcd_done  in  1  from core done
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  W  GCD result
out_err  out  1  result aborted by timeout
busy  out  1  FSM not in IDLE
fifo_count  out  $clog2(DEPTH+1)  pairs currently buffered

Behaviour:
- Reset values (async on rst_n low): all outputs 0 except in_ready=1; FSM=IDLE; FIFO empty; timeout counter 0.
- FIFO:
  - push when in_valid && in_ready; in_ready = (fifo_count < DEPTH).
  - When full, no push is taken even in a pop cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Order is strictly FIFO; pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT.
- IDLE:
  - Pop only if fifo_count>0 && out_valid==0; the pair is latched into op_a/op_b.
  - If op A==0 or B==0: bypass, no core access. out_result = the nonzero operand (0 if both zero), out_err=0, out_valid=1 next cycle. FSM stays IDLE.
  - Otherwise go to LOAD_A.
- LOAD_A: gcd_start=1, gcd_data=op_a, one cycle; go to LOAD_B.
- LOAD_B: gcd_start=1, gcd_data=op_b, one cycle; go to WAIT; clear the timeout counter.
- WAIT:
  - gcd_start=0; gcd_data holds op_b; the counter increments each cycle.
  - gcd_done=1: capture gcd_result into out_result, out_err=0, out_valid=1 next cycle; go to IDLE.
  - Counter reaches TIMEOUT-1 without done: out_result=0, out_err=1, out_valid=1; go to IDLE.
  - If done and timeout coincide, done wins.
- gcd_done is ignored outside WAIT.
- Latency: pop at cycle t; gcd_start high at t+1 and t+2; done sampled at cycle d gives out_valid at d+1. Bypass pop at t gives out_valid at t+1.
- Output register:
  - out_valid, out_result and out_err stay stable until out_valid && out_ready.
  - The acceptance cycle drops out_valid the next cycle.
  - No new pop occurs while out_valid=1 (one-cycle bubble between jobs is accepted).
- busy = (state != IDLE).
- rst_n asserted mid-job aborts the job immediately and discards FIFO contents. A later gcd_done from the core is ignored because the FSM is in IDLE.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

Test Plan:
- Push (143,78); core model asserts done with result 13 after 10 WAIT cycles. Required: gcd_start high exactly 2 cycles with gcd_data 143 then 78; out_result=13, out_err=0.
- Push (0,35), then (42,0), then (0,0). Required: gcd_start never asserts; results 35, 42, 0 with out_valid one cycle after each pop.
- DEPTH=4: push 5 pairs back-to-back while the core is stalled. Required: in_ready=0 after the 4th push, fifo_count=4; the 5th pair is taken only after a pop; all results come out in push order (e.g. (12,18)->6, (35,14)->7, (9,6)->3, (17,5)->1, (100,75)->25).
- Hold out_ready=0 for 20 cycles with a result pending. Required: out_valid/out_result stable, no gcd_start pulse, fifo_count unchanged; the next job starts after the handshake.
- TIMEOUT=16, core never asserts done. Required: out_valid=1, out_err=1, out_result=0 exactly 16 WAIT cycles after LOAD_B; the next queued pair then proceeds normally.
- Assert rst_n=0 during WAIT with 2 pairs queued, release, then pulse gcd_done. Required: all outputs at reset values, fifo_count=0, no out_valid generated.
